// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives one-hot operands to an ALU, waits SETTLE_CYCLES, encodes the one-hot result.
// Define OP_COUNTER_EN to get a wrapping completed-operation counter on op_count.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_a,
  input  logic [3:0]  cmd_b,
  input  logic [2:0]  cmd_opc,
  output logic [15:0] alu_inp1,
  output logic [15:0] alu_inp2,
  output logic [2:0]  alu_opc,
  input  logic [15:0] alu_out,
  input  logic        alu_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_data,
  output logic        rsp_overflow,
  output logic        rsp_error,
  output logic [7:0]  op_count
);
  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d, cnt_q, cnt_d, data_q, data_d, enc;
  logic [2:0] opc_q, opc_d;
  logic       ovf_q, ovf_d, err_q, err_d;
  logic [4:0] pop;
  always_comb begin
    enc = '0;
    pop = '0;
    for (int i = 0; i < 16; i++) if (alu_out[i]) begin
      enc = 4'(i);
      pop = pop + 5'd1;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    opc_d = opc_q;
    cnt_d = cnt_q;
    data_d = data_q;
    ovf_d = ovf_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        a_d = cmd_a;
        b_d = cmd_b;
        opc_d = cmd_opc;
        cnt_d = 4'(SETTLE_CYCLES);
        state_d = DRIVE;
      end
      DRIVE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          data_d = (pop == 5'd1) ? enc : 4'd0;
          err_d = pop != 5'd1;
          ovf_d = alu_overflow;
          state_d = RESP;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      opc_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      opc_q <= opc_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign alu_inp1 = (state_q == IDLE) ? 16'd0 : 16'd1 << a_q;
  assign alu_inp2 = (state_q == IDLE) ? 16'd0 : 16'd1 << b_q;
  assign alu_opc = (state_q == IDLE) ? 3'd0 : opc_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_data = data_q;
  assign rsp_overflow = ovf_q;
  assign rsp_error = err_q;
`ifdef OP_COUNTER_EN
  logic [7:0] op_count_q, op_count_d;
  always_comb op_count_d = op_count_q + {7'd0, rsp_valid && rsp_ready};
  always_ff @(posedge clk) op_count_q <= rst ? 8'd0 : op_count_d;
  assign op_count = op_count_q;
`else
  assign op_count = 8'd0;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed checks of alu_op_sequencer (SETTLE_CYCLES=2); inputs driven and outputs sampled at negedge.
module tb_alu_op_sequencer;
  logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_ready;
  logic [3:0]  cmd_a = '0, cmd_b = '0, rsp_data;
  logic [2:0]  cmd_opc = '0, alu_opc;
  logic [15:0] alu_inp1, alu_inp2, alu_out = '0;
  logic        alu_overflow = 1'b0, rsp_valid, rsp_ready = 1'b0, rsp_overflow, rsp_error;
  logic [7:0]  op_count;
  int errors = 0, checks = 0, n_ops = 0;

  alu_op_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opc(cmd_opc),
    .alu_inp1(alu_inp1), .alu_inp2(alu_inp2), .alu_opc(alu_opc),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_overflow(rsp_overflow), .rsp_error(rsp_error), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_count();
`ifdef OP_COUNTER_EN
    return 8'(n_ops);
`else
    return 8'd0;
`endif
  endfunction

  // Issues a command and walks it to the RESP cycle (N+3); leaves rsp_ready low.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] opc,
                       input logic [15:0] res, input logic ovf, input bit quiet);
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_opc = opc; alu_out = res; alu_overflow = ovf;
    if (!quiet) chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_a = ~a; cmd_b = ~b; cmd_opc = ~opc;
    if (!quiet) begin
      chk("inp1_drive", alu_inp1, 16'd1 << a);
      chk("inp2_drive", alu_inp2, 16'd1 << b);
      chk("opc_drive", alu_opc, opc);
      chk("cmd_ready_drive", cmd_ready, 0);
      chk("rsp_valid_n1", rsp_valid, 0);
    end
    @(negedge clk);
    if (!quiet) chk("rsp_valid_n2", rsp_valid, 0);
    @(negedge clk);
    if (!quiet) chk("rsp_valid_n3", rsp_valid, 1);
  endtask

  task automatic complete(input bit quiet);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_ops++;
    if (!quiet) begin
      chk("rsp_valid_after", rsp_valid, 0);
      chk("cmd_ready_after", cmd_ready, 1);
      chk("inp1_idle", alu_inp1, 0);
      chk("op_count", op_count, exp_count());
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_inp1", alu_inp1, 0);
    chk("rst_inp2", alu_inp2, 0);
    chk("rst_opc", alu_opc, 0);
    chk("rst_rsp", {rsp_valid, rsp_data, rsp_overflow, rsp_error}, 0);
    chk("rst_op_count", op_count, 0);

    issue(4'd3, 4'd5, 3'd0, 16'h0100, 1'b0, 0);
    chk("a3b5_data", rsp_data, 8);
    chk("a3b5_err", rsp_error, 0);
    chk("a3b5_ovf", rsp_overflow, 0);
    complete(0);
    chk("data_retained", rsp_data, 8);

    issue(4'd0, 4'd15, 3'd7, 16'h0000, 1'b0, 0);
    chk("zero_err", rsp_error, 1);
    chk("zero_data", rsp_data, 0);
    complete(0);

    issue(4'd6, 4'd9, 3'd2, 16'h0011, 1'b1, 0);
    chk("multi_err", rsp_error, 1);
    chk("multi_data", rsp_data, 0);
    chk("multi_ovf", rsp_overflow, 1);
    complete(0);

    issue(4'd15, 4'd15, 3'd5, 16'h8000, 1'b1, 0);
    chk("ovf_data", rsp_data, 15);
    chk("ovf_flag", rsp_overflow, 1);
    chk("ovf_err", rsp_error, 0);
    alu_out = 16'h0004; alu_overflow = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_resp", {rsp_data, rsp_overflow, rsp_error}, {4'd15, 1'b1, 1'b0});
      chk("hold_cmd_ready", cmd_ready, 0);
      @(negedge clk);
    end
    chk("hold_after5", {rsp_valid, rsp_data}, {1'b1, 4'd15});
    complete(0);

    issue(4'd2, 4'd4, 3'd1, 16'h0002, 1'b1, 1);
    rst = 1'b0;
    // Reset during DRIVE: re-issue and hit reset one cycle after the handshake.
    complete(1);
    cmd_valid = 1'b1; cmd_a = 4'd7; cmd_b = 4'd8; cmd_opc = 3'd3; alu_out = 16'h0040; alu_overflow = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pre_rst_drive", alu_inp1, 16'h0080);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drive_outs", {alu_inp1, alu_inp2, alu_opc}, 0);
    chk("rst_drive_rsp", {rsp_valid, rsp_data, rsp_overflow, rsp_error}, 0);
    chk("rst_drive_cmd_ready", cmd_ready, 0);
    chk("rst_drive_count", op_count, 0);
    n_ops = 0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_rsp_after_rst", rsp_valid, 0);
    end
    issue(4'd1, 4'd2, 3'd4, 16'h0008, 1'b0, 0);
    chk("fresh_data", rsp_data, 3);
    chk("fresh_err", rsp_error, 0);
    complete(0);

    for (int i = 0; i < 257; i++) begin
      issue(4'(i), 4'(i + 1), 3'(i), 16'd1 << (i % 16), 1'b0, 1);
      complete(1);
      if (i == 0 || i == 254 || i == 255) chk("wrap_count", op_count, exp_count());
    end
    chk("final_count", op_count, exp_count());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
